// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: assembles MSB-first WIDTH-bit words from a qualified
// bit stream, aborts partial words after GAP_MAX idle cycles, and queues results in a 2-deep FIFO.
module s2p_rx #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned GAP_MAX = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             data,
  input  logic             vld,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             abort,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned GapW = $clog2(GAP_MAX + 1);

  typedef enum logic {StIdle, StRecv} state_e;

  state_e           state_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;

  logic [WIDTH-1:0] word;
  logic             push;
  logic             push_ok;
  logic             pop;

  always_comb begin
    word     = {shreg_q[WIDTH-2:0], data};
    push     = vld && (bit_cnt_q == CntW'(WIDTH - 1));
    dout_vld = (count_q != 2'd0);
    pop      = dout_vld && dout_rdy;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok  = push && ((count_q != 2'd2) || pop);
    dout     = dout_vld ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      abort     <= 1'b0;
      ovf       <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (clr) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      abort     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (vld) begin
        shreg_q   <= word;
        gap_cnt_q <= '0;
        if (push) begin
          bit_cnt_q <= '0;
          state_q   <= StIdle;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          state_q   <= StRecv;
        end
      end else if (state_q == StRecv) begin
        if (gap_cnt_q == GapW'(GAP_MAX - 1)) begin
          bit_cnt_q <= '0;
          gap_cnt_q <= '0;
          shreg_q   <= '0;
          state_q   <= StIdle;
          abort     <= 1'b1;
        end else begin
          gap_cnt_q <= gap_cnt_q + 1'b1;
        end
      end

      if (push_ok) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (push && !push_ok) ovf <= 1'b1;
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_rx.sv
// Directed, table-driven bench for s2p_rx (WIDTH=4, GAP_MAX=2).
module tb_s2p_rx;

  logic       clk;
  logic       n_rst;
  logic       data;
  logic       vld;
  logic       clr;
  logic       dout_rdy;
  logic [3:0] dout;
  logic       dout_vld;
  logic       abort;
  logic       ovf;

  int checks;
  int failures;

  typedef struct {
    logic       d;
    logic       v;
    logic       c;
    logic       r;
    logic [3:0] e_dout;
    logic       e_vld;
    logic       e_abort;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  s2p_rx #(.WIDTH(4), .GAP_MAX(2)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .data     (data),
    .vld      (vld),
    .clr      (clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .abort    (abort),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic v, input logic c, input logic r,
                     input logic [3:0] ed, input logic ev, input logic ea, input logic eo);
    vec_t t;
    t.d = d; t.v = v; t.c = c; t.r = r;
    t.e_dout = ed; t.e_vld = ev; t.e_abort = ea; t.e_ovf = eo;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs and compare outputs just after the following edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    data = t.d; vld = t.v; clr = t.c; dout_rdy = t.r;
    @(posedge clk);
    #1;
    check({tag, " dout"}, int'(dout), int'(t.e_dout));
    check({tag, " dout_vld"}, int'(dout_vld), int'(t.e_vld));
    check({tag, " abort"}, int'(abort), int'(t.e_abort));
    check({tag, " ovf"}, int'(ovf), int'(t.e_ovf));
  endtask

  initial begin
    checks = 0; failures = 0;
    n_rst = 1'b0; data = 1'b0; vld = 1'b0; clr = 1'b0; dout_rdy = 1'b0;
    #2;
    check("reset dout", int'(dout), 0);
    check("reset dout_vld", int'(dout_vld), 0);
    check("reset abort", int'(abort), 0);
    check("reset ovf", int'(ovf), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Word 1011, consumed immediately.
    add(1,1,0,1, 4'h0,0,0,0); add(0,1,0,1, 4'h0,0,0,0);
    add(1,1,0,1, 4'h0,0,0,0); add(1,1,0,1, 4'hB,1,0,0);
    add(0,0,0,1, 4'h0,0,0,0);
    // One-cycle gap tolerated: 1101.
    add(1,1,0,1, 4'h0,0,0,0); add(1,1,0,1, 4'h0,0,0,0);
    add(1,0,0,1, 4'h0,0,0,0); add(0,1,0,1, 4'h0,0,0,0);
    add(1,1,0,1, 4'hD,1,0,0); add(0,0,0,1, 4'h0,0,0,0);
    // Two-cycle gap aborts, then 0110.
    add(1,1,0,1, 4'h0,0,0,0); add(0,1,0,1, 4'h0,0,0,0);
    add(0,0,0,1, 4'h0,0,0,0); add(0,0,0,1, 4'h0,0,1,0);
    add(0,0,0,1, 4'h0,0,0,0);
    add(0,1,0,1, 4'h0,0,0,0); add(1,1,0,1, 4'h0,0,0,0);
    add(1,1,0,1, 4'h0,0,0,0); add(0,1,0,1, 4'h6,1,0,0);
    add(0,0,0,1, 4'h0,0,0,0);
    // Overflow: 1,2,3 back-to-back with no consumer.
    add(0,1,0,0, 4'h0,0,0,0); add(0,1,0,0, 4'h0,0,0,0);
    add(0,1,0,0, 4'h0,0,0,0); add(1,1,0,0, 4'h1,1,0,0);
    add(0,1,0,0, 4'h1,1,0,0); add(0,1,0,0, 4'h1,1,0,0);
    add(1,1,0,0, 4'h1,1,0,0); add(0,1,0,0, 4'h1,1,0,0);
    add(0,1,0,0, 4'h1,1,0,0); add(0,1,0,0, 4'h1,1,0,0);
    add(1,1,0,0, 4'h1,1,0,0); add(1,1,0,0, 4'h1,1,0,1);
    add(0,0,0,1, 4'h2,1,0,1); add(0,0,0,1, 4'h0,0,0,1);
    add(0,0,0,1, 4'h0,0,0,1);
    // Fill with 5, A; two partial bits; clr with a stray bit; then 1001.
    add(0,1,0,0, 4'h0,0,0,1); add(1,1,0,0, 4'h0,0,0,1);
    add(0,1,0,0, 4'h0,0,0,1); add(1,1,0,0, 4'h5,1,0,1);
    add(1,1,0,0, 4'h5,1,0,1); add(0,1,0,0, 4'h5,1,0,1);
    add(1,1,0,0, 4'h5,1,0,1); add(0,1,0,0, 4'h5,1,0,1);
    add(1,1,0,0, 4'h5,1,0,1); add(1,1,0,0, 4'h5,1,0,1);
    add(1,1,1,0, 4'h0,0,0,0);
    add(1,1,0,1, 4'h0,0,0,0); add(0,1,0,1, 4'h0,0,0,0);
    add(0,1,0,1, 4'h0,0,0,0); add(1,1,0,1, 4'h9,1,0,0);
    add(0,0,0,1, 4'h0,0,0,0);
    // Full FIFO (3, C) with push and pop on the same edge (7).
    add(0,1,0,0, 4'h0,0,0,0); add(0,1,0,0, 4'h0,0,0,0);
    add(1,1,0,0, 4'h0,0,0,0); add(1,1,0,0, 4'h3,1,0,0);
    add(1,1,0,0, 4'h3,1,0,0); add(1,1,0,0, 4'h3,1,0,0);
    add(0,1,0,0, 4'h3,1,0,0); add(0,1,0,0, 4'h3,1,0,0);
    add(0,1,0,0, 4'h3,1,0,0); add(1,1,0,0, 4'h3,1,0,0);
    add(1,1,0,0, 4'h3,1,0,0); add(1,1,0,1, 4'hC,1,0,0);
    add(0,0,0,1, 4'h7,1,0,0); add(0,0,0,1, 4'h0,0,0,0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Asynchronous reset mid-word with the FIFO holding E.
    vecs.delete();
    add(1,1,0,0, 4'h0,0,0,0); add(1,1,0,0, 4'h0,0,0,0);
    add(1,1,0,0, 4'h0,0,0,0); add(0,1,0,0, 4'hE,1,0,0);
    add(1,1,0,0, 4'hE,1,0,0); add(1,1,0,0, 4'hE,1,0,0);
    foreach (vecs[i]) apply(vecs[i], $sformatf("pre_rst%0d", i));
    @(negedge clk);
    vld = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("async rst dout", int'(dout), 0);
    check("async rst dout_vld", int'(dout_vld), 0);
    check("async rst abort", int'(abort), 0);
    check("async rst ovf", int'(ovf), 0);
    @(negedge clk);
    n_rst = 1'b1;
    vecs.delete();
    add(0,0,0,1, 4'h0,0,0,0); add(0,0,0,1, 4'h0,0,0,0);
    add(0,1,0,1, 4'h0,0,0,0); add(1,1,0,1, 4'h0,0,0,0);
    add(0,1,0,1, 4'h0,0,0,0); add(1,1,0,1, 4'h5,1,0,0);
    add(0,0,0,1, 4'h0,0,0,0);
    foreach (vecs[i]) apply(vecs[i], $sformatf("post_rst%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter WIDTH, default 4, word length in bits (legal range 2..16).
REQ-002 Parameter GAP_MAX, default 2, consecutive idle cycles tolerated inside a word before abort (legal range >=1).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 data  input  1  serial bit, MSB of word first.
REQ-006 vld  input  1  data qualifier; data is sampled on a rising clk edge only when vld=1.
REQ-007 clr  input  1  synchronous clear of receiver, FIFO and flags.
REQ-008 dout  output  WIDTH  head word of the output FIFO; all-zero when the FIFO is empty.
REQ-009 dout_vld  output  1  FIFO non-empty.
REQ-010 dout_rdy  input  1  consumer accept; a pop occurs when dout_vld=1 and dout_rdy=1.
REQ-011 abort  output  1  one-cycle pulse: partial word discarded.
REQ-012 ovf  output  1  sticky: a completed word was dropped because the FIFO was full.

Function
REQ-013 The receiver SHALL have two states: IDLE (bit count 0) and RECV (bit count 1..WIDTH-1).
REQ-014 On each edge with vld=1, the shift register SHALL shift left with data entering at bit 0, and the bit count SHALL increment.
REQ-015 On the edge that samples bit WIDTH (the last bit), the assembled word {previous WIDTH-1 bits, data} SHALL be pushed to the FIFO, the bit count SHALL return to 0 and the state to IDLE.
REQ-016 Latency: the pushed word SHALL appear at dout with dout_vld=1 in the cycle immediately after the last-bit edge if the FIFO was empty.
REQ-017 Back-to-back words (vld held high) SHALL be accepted with no dead cycle between them.
REQ-018 In RECV, a gap counter SHALL count consecutive edges with vld=0 and clear to 0 on any edge with vld=1.
REQ-019 When the gap counter reaches GAP_MAX, the partial word SHALL be discarded, the bit count and gap counter cleared, the state set to IDLE, and abort driven high for exactly the following cycle.
REQ-020 In IDLE, vld=0 SHALL have no effect; the gap counter SHALL hold 0.
REQ-021 The FIFO SHALL be two entries deep, first-in first-out.
REQ-022 A push and a pop on the same edge SHALL both take effect in every occupancy state, including full.
REQ-023 A push when full without a simultaneous pop SHALL drop the new word, keep the FIFO contents, and set ovf to 1.
REQ-024 ovf SHALL remain 1 until clr or reset.
REQ-025 A pop when the FIFO is empty SHALL be impossible (dout_vld=0) and dout_rdy SHALL then be ignored.
REQ-026 clr=1 SHALL, on that edge, empty the FIFO, clear the bit count, gap counter, shift register, ovf and abort, and set the state to IDLE; a data/vld bit on the same edge SHALL be ignored.
REQ-027 clr SHALL take priority over push, pop and abort on the same edge.
REQ-028 All outputs SHALL be registered or derived solely from registered state; there SHALL be no combinational path from data/vld to any output.

Reset
REQ-029 While n_rst=0, independent of clk: dout=0, dout_vld=0, abort=0, ovf=0, FIFO empty, state IDLE, all counters and the shift register 0.
REQ-030 Reset asserted mid-word SHALL discard the partial word with no abort pulse; reception SHALL restart from bit 1 after release.

Verification (WIDTH=4, GAP_MAX=2)
REQ-031 vld=1 for 4 edges with data 1,0,1,1, dout_rdy=1 -> next cycle dout=4'b1011, dout_vld=1 for exactly one cycle, abort=0.
REQ-032 Data 1,1, one vld=0 cycle, then 0,1 -> dout=4'b1101, abort never asserted.
REQ-033 Data 1,0, then two vld=0 cycles -> one-cycle abort pulse, no push; then 0,1,1,0 -> dout=4'b0110.
REQ-034 dout_rdy=0, words 4'h1, 4'h2, 4'h3 sent back-to-back -> FIFO holds 1,2 and ovf=1; then dout_rdy=1 -> dout shows 4'h1 then 4'h2, then dout_vld=0 with ovf still 1.
REQ-035 FIFO full, ovf=1, 2 bits of a partial word received, clr pulsed -> dout_vld=0, dout=0, ovf=0; next 4-bit word is received correctly.
REQ-036 n_rst pulsed low between clock edges mid-word with FIFO non-empty -> all outputs 0 immediately; after release, data 0,1,0,1 -> dout=4'b0101.
